// File: rtl/tdm_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds an even-parity fifth slot).
package tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    // The parity bit follows the last data slot; it is tracked by a flag
    // rather than by widening the slot counter.
    localparam int PARITY_SLOT = NUM_SLOTS;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: restarts at 1 on a sync strobe,
// advances on plain enabled slots while a frame is running, wraps after the
// last data slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              advance,
    output logic [SLOT_W-1:0] slot
);

    // Sync always starts a new frame at slot 1; otherwise step only when allowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (en) begin
            if (sync) begin
                slot <= SLOT_W'(1);
            end else if (advance) begin
                slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux14.sv
// 1-to-4 TDM demultiplexer: collects one serial bit per enabled slot and
// publishes a whole frame on y0..y3 at once.
// Optional feature macro: TDM_DEMUX_PARITY_EN (fifth slot carries even parity;
// outputs update only when parity checks out).
module tdm_demux14
    import tdm_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
)
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync,
    input  logic din,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic s0,
    output logic s1,
    output logic frame_valid,
    output logic sync_err,
    output logic par_err
);

    state_t                 state;
    logic [SLOT_W-1:0]      slot;
    logic [NUM_SLOTS-2:0]   shadow;
    logic                   advance;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_phase;
    logic last_bit;

    assign advance = (state == RUN) && !par_phase;
`else
    assign advance = (state == RUN);
    assign par_err = 1'b0;
`endif

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .advance (advance),
        .slot    (slot)
    );

    assign s0 = slot[0];
    assign s1 = slot[1];

    // Frame FSM: capture bits into the shadow, publish complete frames, flag resyncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            y0          <= RESET_VAL;
            y1          <= RESET_VAL;
            y2          <= RESET_VAL;
            y3          <= RESET_VAL;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_phase   <= 1'b0;
            last_bit    <= 1'b0;
            par_err     <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err     <= 1'b0;
`endif
            if (en) begin
                if (sync) begin
                    shadow   <= {{(NUM_SLOTS-2){1'b0}}, din};
                    sync_err <= (state == RUN);
                    state    <= RUN;
`ifdef TDM_DEMUX_PARITY_EN
                    par_phase <= 1'b0;
`endif
                end else if (state == RUN) begin
`ifdef TDM_DEMUX_PARITY_EN
                    if (par_phase) begin
                        if ((^shadow ^ last_bit ^ din) == 1'b0) begin
                            y0          <= shadow[0];
                            y1          <= shadow[1];
                            y2          <= shadow[2];
                            y3          <= last_bit;
                            frame_valid <= 1'b1;
                        end else begin
                            par_err <= 1'b1;
                        end
                        par_phase <= 1'b0;
                        state     <= IDLE;
                    end else if (slot == LAST_SLOT) begin
                        last_bit  <= din;
                        par_phase <= 1'b1;
                    end else begin
                        shadow[slot] <= din;
                    end
`else
                    if (slot == LAST_SLOT) begin
                        y0          <= shadow[0];
                        y1          <= shadow[1];
                        y2          <= shadow[2];
                        y3          <= din;
                        frame_valid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        shadow[slot] <= din;
                    end
`endif
                end
            end
        end
    end

endmodule
